// File: rtl/ex_div_ctrl.sv
// Radix-2 restoring 32-bit div/mod sequencer for EX; DIV_EARLY_OUT_EN enables a 1-cycle path for trivial quotients.
// Latency: 33 cycles from acceptance to DONE (1 cycle on early-out); zero added latency for non-div instructions.
// Backpressure: holds EX via es_ready_go while busy; result held in DONE until ms_allowin.
`timescale 1ns/1ps
module ex_div_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        div_req,
    input  logic [1:0]  div_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        ms_allowin,
    input  logic        flush,
    output logic        es_ready_go,
    output logic [31:0] div_result,
    output logic        div_busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] dvd_q, dvd_d;     // dividend in, quotient bits shift in from the bottom
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mod_q, mod_d;
    logic        s1neg_q, s1neg_d;
    logic        qneg_q, qneg_d;
    logic        dvz_q, dvz_d;
    logic [31:0] res_q, res_d;

    logic [31:0] abs1, abs2;
    logic [32:0] trial, diff;
    logic        qbit;
    logic [31:0] rem_nxt, quo_nxt, quo_fin, rem_fin;

    always_comb begin
        abs1    = (~div_op[1] & src1[31]) ? (~src1 + 32'd1) : src1;
        abs2    = (~div_op[1] & src2[31]) ? (~src2 + 32'd1) : src2;
        trial   = {rem_q, dvd_q[31]};
        diff    = trial - {1'b0, dvs_q};
        qbit    = ~diff[32];
        rem_nxt = qbit ? diff[31:0] : trial[31:0];
        quo_nxt = {dvd_q[30:0], qbit};
        // Zero divisor bypasses quotient sign correction; the remainder naturally returns src1.
        quo_fin = dvz_q ? 32'hFFFF_FFFF : (qneg_q ? (~quo_nxt + 32'd1) : quo_nxt);
        rem_fin = s1neg_q ? (~rem_nxt + 32'd1) : rem_nxt;

        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        mod_d   = mod_q;
        s1neg_d = s1neg_q;
        qneg_d  = qneg_q;
        dvz_d   = dvz_q;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (ex_valid & div_req & ~flush) begin
                    dvd_d   = abs1;
                    dvs_d   = abs2;
                    rem_d   = 32'd0;
                    cnt_d   = 5'd0;
                    mod_d   = div_op[0];
                    s1neg_d = ~div_op[1] & src1[31];
                    qneg_d  = ~div_op[1] & (src1[31] ^ src2[31]);
                    dvz_d   = (src2 == 32'd0);
                    state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                    if ((src2 == 32'd0) || (abs1 < abs2)) begin
                        state_d = S_DONE;
                        res_d   = div_op[0] ? src1 : ((src2 == 32'd0) ? 32'hFFFF_FFFF : 32'd0);
                    end
`endif
                end
            end
            S_CALC: begin
                dvd_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    res_d   = mod_q ? rem_fin : quo_fin;
                end
            end
            S_DONE: begin
                if (ms_allowin) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            rem_q   <= 32'd0;
            cnt_q   <= 5'd0;
            mod_q   <= 1'b0;
            s1neg_q <= 1'b0;
            qneg_q  <= 1'b0;
            dvz_q   <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            mod_q   <= mod_d;
            s1neg_q <= s1neg_d;
            qneg_q  <= qneg_d;
            dvz_q   <= dvz_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:  es_ready_go = ~(ex_valid & div_req);
            S_CALC:  es_ready_go = 1'b0;
            S_DONE:  es_ready_go = 1'b1;
            default: es_ready_go = 1'b0;
        endcase
    end

    assign div_result = res_q;
    assign div_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Self-checking bench for ex_div_ctrl: directed vectors, random ops vs arithmetic model, flush, backpressure, async reset.
`timescale 1ns/1ps
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, div_req, ms_allowin, flush;
    logic [1:0]  div_op;
    logic [31:0] src1, src2;
    logic        es_ready_go, div_busy;
    logic [31:0] div_result;

    int chk_cnt  = 0;
    int pass_cnt = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    ex_div_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .ex_valid   (ex_valid),
        .div_req    (div_req),
        .div_op     (div_op),
        .src1       (src1),
        .src2       (src2),
        .ms_allowin (ms_allowin),
        .flush      (flush),
        .es_ready_go(es_ready_go),
        .div_result (div_result),
        .div_busy   (div_busy)
    );

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
        if (op[1]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[0] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit ref_early(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        longint ma, mb;
        if (op[1]) begin
            ma = longint'({32'd0, a});
            mb = longint'({32'd0, b});
        end else begin
            ma = longint'($signed(a));
            mb = longint'($signed(b));
            if (ma < 0) ma = -ma;
            if (mb < 0) mb = -mb;
        end
        return (b == 32'd0) || (ma < mb);
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        return (EARLY_EN && ref_early(a, b, op)) ? 0 : 32;
    endfunction

    // Caller is at posedge+1. Returns result, count of es_ready_go=0 cycles after acceptance,
    // stability over `hold` backpressured DONE cycles, and div_busy in the request cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input int hold,
                         output logic [31:0] res, output int lat, output bit stable, output logic busy_t);
        ex_valid = 1'b1; div_req = 1'b1; src1 = a; src2 = b; div_op = op; ms_allowin = 1'b0;
        @(negedge clk);
        busy_t = div_busy;
        @(posedge clk); #1;
        src1 = $urandom; src2 = $urandom;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (es_ready_go === 1'b1) begin
                lat = i;
                break;
            end
        end
        res = div_result;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (es_ready_go !== 1'b1 || div_result !== res) stable = 1'b0;
        end
        ms_allowin = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; div_req = 1'b0; ms_allowin = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ex_valid = 1'b0; div_req = 1'b0; div_op = 2'b00;
        src1 = 32'd0; src2 = 32'd0; ms_allowin = 1'b0; flush = 1'b0;
        #12;
        chk_cnt++;
        if (div_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", div_busy); else pass_cnt++;
        chk_cnt++;
        if (div_result !== 32'd0) $display("FAIL reset_result got=%h want=0", div_result); else pass_cnt++;
        chk_cnt++;
        if (es_ready_go !== 1'b1) $display("FAIL reset_ready got=%b want=1", es_ready_go); else pass_cnt++;
        #5 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [31:0] va[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                                32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb[10] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [1:0]  vo[10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
        logic [31:0] ve[10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd1,
                                32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678,
                                32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat;
        bit stable;
        logic busy_t;
        for (int i = 0; i < 10; i++) begin
            issue(va[i], vb[i], vo[i], 0, res, lat, stable, busy_t);
            chk_cnt++;
            if (res !== ve[i]) $display("FAIL vec%0d_result got=%h want=%h", i, res, ve[i]); else pass_cnt++;
            chk_cnt++;
            if (lat != ref_lat(va[i], vb[i], vo[i]))
                $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat, ref_lat(va[i], vb[i], vo[i]));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res;
        logic [1:0]  op;
        int lat;
        bit stable;
        logic busy_t;
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: a = 32'($urandom_range(0, 100));
                2: b = {{16{b[31]}}, b[15:0]};
                default: ;
            endcase
            issue(a, b, op, 0, res, lat, stable, busy_t);
            chk_cnt++;
            if (res !== ref_div(a, b, op))
                $display("FAIL rand%0d_result a=%h b=%h op=%b got=%h want=%h", i, a, b, op, res, ref_div(a, b, op));
            else pass_cnt++;
            chk_cnt++;
            if (lat != ref_lat(a, b, op)) $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, ref_lat(a, b, op));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        int lat;
        bit stable;
        logic busy_t;
        issue(32'd100, 32'd7, 2'b10, 5, res, lat, stable, busy_t);
        chk_cnt++;
        if (res !== 32'd14) $display("FAIL bp_result got=%h want=%h", res, 32'd14); else pass_cnt++;
        chk_cnt++;
        if (stable !== 1'b1) $display("FAIL bp_hold_stable got=%b want=1", stable); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        int lat;
        bit stable;
        logic busy_t;
        prev = div_result;
        ex_valid = 1'b1; div_req = 1'b1; src1 = 32'hFFFF_FFF0; src2 = 32'd3; div_op = 2'b00;
        @(posedge clk); #1;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1; ex_valid = 1'b0; div_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (div_busy !== 1'b1) $display("FAIL flush_pre_busy got=%b want=1", div_busy); else pass_cnt++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (div_busy !== 1'b0) $display("FAIL flush_busy got=%b want=0", div_busy); else pass_cnt++;
        chk_cnt++;
        if (div_result !== prev) $display("FAIL flush_result got=%h want=%h", div_result, prev); else pass_cnt++;
        chk_cnt++;
        if (es_ready_go !== 1'b1) $display("FAIL flush_ready got=%b want=1", es_ready_go); else pass_cnt++;
        @(posedge clk); #1;
        ex_valid = 1'b1; div_req = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; div_req = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (div_busy !== 1'b0) $display("FAIL flush_req_busy got=%b want=0", div_busy); else pass_cnt++;
        @(posedge clk); #1;
        issue(32'hFFFF_FFF0, 32'd3, 2'b00, 0, res, lat, stable, busy_t);
        chk_cnt++;
        if (res !== 32'hFFFF_FFFB) $display("FAIL flush_after_result got=%h want=%h", res, 32'hFFFF_FFFB); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        ex_valid = 1'b1; div_req = 1'b1; src1 = 32'd1000; src2 = 32'd3; div_op = 2'b10;
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        chk_cnt++;
        if (div_busy !== 1'b1) $display("FAIL arst_pre_busy got=%b want=1", div_busy); else pass_cnt++;
        #3;
        resetn = 1'b0; ex_valid = 1'b0; div_req = 1'b0;
        #1;
        chk_cnt++;
        if (div_busy !== 1'b0) $display("FAIL arst_busy got=%b want=0", div_busy); else pass_cnt++;
        chk_cnt++;
        if (div_result !== 32'd0) $display("FAIL arst_result got=%h want=0", div_result); else pass_cnt++;
        chk_cnt++;
        if (es_ready_go !== 1'b1) $display("FAIL arst_ready got=%b want=1", es_ready_go); else pass_cnt++;
        #2 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, res;
        logic [1:0]  op;
        int lat;
        bit stable;
        logic busy_t;
        for (int i = 0; i < 3; i++) begin
            a  = $urandom;
            b  = 32'($urandom_range(1, 1000));
            op = 2'($urandom_range(0, 3));
            issue(a, b, op, 0, res, lat, stable, busy_t);
            chk_cnt++;
            if (busy_t !== 1'b0) $display("FAIL b2b%0d_idle_pass got=%b want=0", i, busy_t); else pass_cnt++;
            chk_cnt++;
            if (res !== ref_div(a, b, op)) $display("FAIL b2b%0d_result got=%h want=%h", i, res, ref_div(a, b, op));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ex_div_ctrl.md
# ex_div_ctrl

Iterative 32-bit divide sequencer for the EX stage of the five-stage pipeline. Accepts a divide/modulo request from the instruction currently in EX, latches its operands, and runs a radix-2 restoring divider one quotient bit per cycle. While it runs it holds EX by deasserting `es_ready_go`; the result is presented to the EX→MEM register once complete.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  pipeline clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX holds a valid instruction
- `div_req`  in  1  EX instruction is a div/mod; qualified by `ex_valid`
- `div_op`  in  2  [0]=1 remainder (mod), 0 quotient (div); [1]=1 unsigned, 0 signed
- `src1`  in  32  dividend; sampled only at acceptance
- `src2`  in  32  divisor; sampled only at acceptance
- `ms_allowin`  in  1  MEM accepts the EX instruction this cycle
- `flush`  in  1  cancel the in-flight EX instruction
- `es_ready_go`  out  1  EX may hand off this cycle
- `div_result`  out  32  selected quotient or remainder, valid when state is DONE
- `div_busy`  out  1  state is not IDLE

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE, `div_result`=0, `div_busy`=0, iteration counter=0, operand registers=0.
- IDLE: if `ex_valid & div_req & ~flush`: latch |src1|, |src2| (absolute values in signed mode, raw in unsigned), sign of src1, sign of quotient (s1^s2), `div_op`; clear partial remainder; counter=0; → CALC. Otherwise stay.
- CALC: each cycle shift next dividend bit into 33-bit partial remainder, trial-subtract divisor, set quotient bit if non-negative, keep difference. Counter increments; after iteration 31 → DONE.
- DONE: `div_result` registered on entry: quotient negated if quotient sign set (signed), remainder negated if dividend negative (signed); `div_op[0]` selects. Hold until `ms_allowin` → IDLE.
- `es_ready_go` (combinational): IDLE → `~(ex_valid & div_req)`; CALC → 0; DONE → 1.
- `flush` in any state → IDLE next cycle; latched state discarded; `div_result` unchanged.
- Divisor zero: quotient=0xFFFFFFFF, remainder=src1, both modes, no sign correction.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (falls out of abs arithmetic; 2^31 held in 32-bit unsigned).
- Arithmetic: partial remainder 33 bits, all negations two's complement mod 2^32.

## Timing
- Request accepted at edge ending cycle T; CALC cycles T+1..T+32; DONE from T+33; `es_ready_go`=1 first in T+33. Non-div instructions: zero added latency.
- DONE with `ms_allowin`=0: result and `es_ready_go` held indefinitely.
- DONE with `ms_allowin`=1 and a new div already in EX the same cycle: new request not accepted until next cycle (block passes through IDLE), since EX contents change at the same edge.
- `flush` and request in the same IDLE cycle: request ignored.
- Reset asserted mid-CALC: immediate return to IDLE, outputs to reset values.

## Configuration
- `DIV_EARLY_OUT_EN` defined: in IDLE, if divisor zero or |src1| < |src2| (compared after abs), go directly IDLE → DONE, skipping CALC; latency 1 cycle (`es_ready_go` high at T+1); quotient 0, remainder src1 (zero-divisor values per Operation).
- Undefined: every request takes 32 CALC cycles. `div_result` values identical in both builds.

## Test plan
- Signed div: src1=0xFFFFFFF9 (−7), src2=2, div_op=00 → `div_result`=0xFFFFFFFD at T+33; div_op=01 → 0xFFFFFFFF.
- Unsigned div: src1=0xFFFFFFF9, src2=2, div_op=10 → 0x7FFFFFFC; div_op=11 → 1; `es_ready_go`=0 for exactly 32 cycles after acceptance.
- Divide by zero: src1=0x12345678, src2=0 → quotient 0xFFFFFFFF, remainder 0x12345678; with `DIV_EARLY_OUT_EN`, DONE at T+1.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Backpressure and flush: hold `ms_allowin`=0 for 5 cycles in DONE → result stable, `es_ready_go`=1 throughout; assert `flush` at CALC cycle 10 → IDLE next cycle, `div_busy`=0.
- Async reset: drop `resetn` mid-CALC between edges → `div_busy`=0, `div_result`=0 immediately; back-to-back divs after release produce correct results.
